irq_request_latch: RTL and testbench
====================================

IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 irq_in  input  8  interrupt source lines, synchronous to clk; bit 7 is highest priority.
REQ-005 mask  input  8  per-line mask; 1 = line blocked from arbitration.
REQ-006 enc_y  input  3  index returned by the downstream 8-to-3 priority encoder.
REQ-007 irq_ack  input  1  consumer acknowledge of the presented request.
REQ-008 clr_lost  input  1  single-cycle pulse that clears all lost flags.
REQ-009 enc_i  output  8  masked pending vector driven to the encoder i input.
REQ-010 enc_en  output  1  encoder enable.
REQ-011 irq_valid  output  1  a request is being presented.
REQ-012 irq_id  output  3  index of the presented request.
REQ-013 lost  output  8  sticky per-line flag: an event arrived while that line was already pending.

Function
REQ-014 Edge detect: irq_d[7:0] SHALL register irq_in each cycle; event[n] = irq_in[n] & ~irq_d[n].
REQ-015 Pending: an event on line n SHALL set pend[n] at the next rising edge, regardless of mask.
REQ-016 enc_i SHALL equal pend & ~mask (combinational); enc_en SHALL equal |enc_i.
REQ-017 The FSM SHALL have three states: IDLE, VALID and CLEAR.
REQ-018 IDLE -> VALID when enc_en = 1; on that edge, irq_id SHALL capture enc_y.
REQ-019 VALID: irq_valid = 1; irq_id SHALL hold stable; mask changes and new events SHALL NOT alter irq_id or retract irq_valid.
REQ-020 VALID -> CLEAR on irq_ack = 1; on that edge, pend[irq_id] SHALL clear.
REQ-021 CLEAR -> IDLE unconditionally after one cycle, giving the encoder one cycle to settle on the updated pend; irq_valid = 0 in CLEAR.
REQ-022 irq_ack SHALL be ignored in IDLE and CLEAR.
REQ-023 Latency: an event sampled at edge N sets pend at N; irq_valid is high after edge N+1 when the FSM is idle.
REQ-024 Back-to-back requests: after an ack, the next irq_valid SHALL assert no earlier than two cycles after the ack edge.
REQ-025 Lost: an event on line n while pend[n] = 1 and not being cleared that cycle SHALL set lost[n]; pend[n] stays 1.
REQ-026 Ack and an event on the same line in the same cycle: pend[n] SHALL remain 1; lost[n] SHALL NOT set.
REQ-027 clr_lost SHALL clear all lost bits; if an event sets lost[n] in the same cycle, lost[n] SHALL be 1 (set wins).
REQ-028 A masked pending line SHALL stay pending and SHALL be arbitrated once it is unmasked.

Reset
REQ-029 While rst = 1: irq_d = 0, pend = 0, lost = 0, irq_id = 0, irq_valid = 0, state = IDLE; enc_i = 0 and enc_en = 0.
REQ-030 When irq_in[n] is already high at reset release, it SHALL count as one event on the first clock edge.
REQ-031 rst asserted in VALID SHALL drop irq_valid immediately and discard all pending and lost state.

Verification
REQ-032 irq_in = 8'h00 -> 8'h09 (bits 3 and 0), mask = 0 -> irq_valid = 1 with irq_id = 3; ack -> CLEAR, then irq_valid = 1 with irq_id = 0; ack -> enc_en = 0.
REQ-033 mask = 8'h80, event on line 7 -> enc_i = 0 and irq_valid = 0; set mask = 0 -> irq_id = 7 presented.
REQ-034 Line 2 pending and unacked, second rising edge on line 2 -> lost = 8'h04; clr_lost pulse -> lost = 0.
REQ-035 Line 5 in VALID, irq_ack coincides with a new line-5 edge -> after CLEAR, irq_id = 5 presented again; lost[5] = 0.
REQ-036 During VALID with irq_id = 4, an event on line 6 arrives -> irq_id stays 4 until ack, then 6 is presented.
REQ-037 rst pulse mid-VALID with pend = 8'hFF -> all outputs zero within the same cycle; held-high irq_in lines re-register as events after release.

Source files
------------

// File: rtl/irq_request_latch.sv
// Purpose: edge-detect 8 interrupt lines, latch them as pending and present one at a time to a consumer.
// Latency: an edge sampled at edge N sets pend at N; irq_valid rises after edge N+1 when idle.
// Backpressure: a presented request holds until irq_ack; new edges queue in pend, or are flagged lost.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic [7:0] mask,
    input  logic [2:0] enc_y,
    input  logic       irq_ack,
    input  logic       clr_lost,
    output logic [7:0] enc_i,
    output logic       enc_en,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] lost
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] irq_d;
    logic [7:0] pend;
    logic [7:0] irq_event;
    logic [7:0] clr_vec;
    logic [7:0] lost_set;
    logic       capture;
    logic       ack_hit;

    // Rising edges only; irq_d resets to zero so a line held high through reset counts once.
    assign irq_event = irq_in & ~irq_d;

    // Masking only gates arbitration; pending state is kept regardless of mask.
    assign enc_i  = pend & ~mask;
    assign enc_en = |enc_i;

    assign irq_valid = (state == VALID);

    // The acknowledged line is cleared on the ack edge; a coincident edge on that line re-arms it.
    assign clr_vec  = ack_hit ? (8'd1 << irq_id) : 8'd0;
    assign lost_set = irq_event & pend & ~clr_vec;

    // Next-state decode: capture the encoder result on entry to VALID, clear on ack.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc_en) begin
                    state_nxt = VALID;
                    capture   = 1'b1;
                end
            end
            VALID: begin
                if (irq_ack) begin
                    state_nxt = CLEAR;
                    ack_hit   = 1'b1;
                end
            end
            CLEAR: begin
                // One dead cycle so the encoder settles on the updated pend before rearbitration.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Presented index is frozen from capture until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_id <= 3'd0;
        end else if (capture) begin
            irq_id <= enc_y;
        end
    end

    // Edge-detect history and pending vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d <= 8'd0;
            pend  <= 8'd0;
        end else begin
            irq_d <= irq_in;
            pend  <= (pend & ~clr_vec) | irq_event;
        end
    end

    // Sticky lost flags; a new set in the same cycle as clr_lost wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost <= 8'd0;
        end else if (clr_lost) begin
            lost <= lost_set;
        end else begin
            lost <= lost | lost_set;
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Purpose: directed check of irq_request_latch with a behavioural 8-to-3 priority encoder.
// Latency: inputs change and outputs are sampled 1 time unit after each rising clk edge.
// Backpressure: irq_ack is driven by the stimulus sequence directly.
module tb_irq_request_latch;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic [2:0] enc_y;
    logic       irq_ack;
    logic       clr_lost;
    logic [7:0] enc_i;
    logic       enc_en;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] lost;

    int total;
    int bad;

    irq_request_latch dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .enc_y     (enc_y),
        .irq_ack   (irq_ack),
        .clr_lost  (clr_lost),
        .enc_i     (enc_i),
        .enc_en    (enc_en),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream priority encoder model: highest set bit wins.
    always_comb begin
        enc_y = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (enc_i[i]) enc_y = 3'(i);
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        irq_in   = 8'h00;
        mask     = 8'h00;
        irq_ack  = 1'b0;
        clr_lost = 1'b0;
        #2;
        chk("rst_valid", {7'd0, irq_valid}, 8'h00);
        chk("rst_enc_en", {7'd0, enc_en}, 8'h00);
        chk("rst_enc_i", enc_i, 8'h00);
        chk("rst_id", {5'd0, irq_id}, 8'h00);
        chk("rst_lost", lost, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();

        // Two lines at once: 3 first, then 0.
        irq_in = 8'h09;
        step();
        chk("t1_enc_i", enc_i, 8'h09);
        chk("t1_not_yet", {7'd0, irq_valid}, 8'h00);
        step();
        chk("t1_valid3", {7'd0, irq_valid}, 8'h01);
        chk("t1_id3", {5'd0, irq_id}, 8'h03);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t1_clear", {7'd0, irq_valid}, 8'h00);
        chk("t1_pend_after_ack", enc_i, 8'h01);
        step();
        chk("t1_idle_gap", {7'd0, irq_valid}, 8'h00);
        step();
        chk("t1_valid0", {7'd0, irq_valid}, 8'h01);
        chk("t1_id0", {5'd0, irq_id}, 8'h00);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t1_enc_en_off", {7'd0, enc_en}, 8'h00);
        step();
        irq_in = 8'h00;
        step();

        // Masked line stays pending and is served once unmasked.
        mask   = 8'h80;
        irq_in = 8'h80;
        step();
        chk("t2_enc_i_masked", enc_i, 8'h00);
        step();
        chk("t2_no_valid", {7'd0, irq_valid}, 8'h00);
        mask = 8'h00;
        #1;
        chk("t2_enc_i_unmasked", enc_i, 8'h80);
        step();
        chk("t2_valid7", {7'd0, irq_valid}, 8'h01);
        chk("t2_id7", {5'd0, irq_id}, 8'h07);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        irq_in = 8'h00;
        step();

        // Second edge on an unacked line sets lost; clr_lost clears, set wins.
        irq_in = 8'h04;
        step();
        step();
        chk("t3_id2", {5'd0, irq_id}, 8'h02);
        irq_in = 8'h00;
        step();
        irq_in = 8'h04;
        step();
        chk("t3_lost", lost, 8'h04);
        chk("t3_still_valid", {7'd0, irq_valid}, 8'h01);
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        chk("t3_lost_clr", lost, 8'h00);
        irq_in = 8'h00;
        step();
        irq_in   = 8'h04;
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        chk("t3_set_wins", lost, 8'h04);
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        chk("t3_lost_clr2", lost, 8'h00);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        irq_in = 8'h00;
        step();

        // Ack coincident with a new edge on the same line; ack held through CLEAR is ignored.
        irq_in = 8'h20;
        step();
        step();
        chk("t4_id5", {5'd0, irq_id}, 8'h05);
        irq_in = 8'h00;
        step();
        irq_in  = 8'h20;
        irq_ack = 1'b1;
        step();
        chk("t4_clear", {7'd0, irq_valid}, 8'h00);
        chk("t4_pend_kept", enc_i, 8'h20);
        chk("t4_no_lost", lost, 8'h00);
        step();
        irq_ack = 1'b0;
        chk("t4_ack_ignored_clear", enc_i, 8'h20);
        step();
        chk("t4_valid_again", {7'd0, irq_valid}, 8'h01);
        chk("t4_id5_again", {5'd0, irq_id}, 8'h05);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        irq_in = 8'h00;
        step();

        // Higher-priority arrival during VALID does not disturb irq_id.
        irq_in = 8'h10;
        step();
        step();
        chk("t5_id4", {5'd0, irq_id}, 8'h04);
        irq_in = 8'h50;
        step();
        chk("t5_id_hold", {5'd0, irq_id}, 8'h04);
        chk("t5_valid_hold", {7'd0, irq_valid}, 8'h01);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();
        chk("t5_id6", {5'd0, irq_id}, 8'h06);
        chk("t5_valid6", {7'd0, irq_valid}, 8'h01);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        irq_in = 8'h00;
        step();

        // Reset mid-VALID with everything pending and lost.
        irq_in = 8'hFF;
        step();
        step();
        irq_in = 8'h00;
        step();
        irq_in = 8'hFF;
        step();
        chk("t6_lost_all", lost, 8'hFF);
        chk("t6_valid7", {5'd0, irq_id}, 8'h07);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {7'd0, irq_valid}, 8'h00);
        chk("t6_rst_enc_i", enc_i, 8'h00);
        chk("t6_rst_lost", lost, 8'h00);
        chk("t6_rst_id", {5'd0, irq_id}, 8'h00);
        step();
        rst = 1'b0;
        step();
        chk("t6_reevent", enc_i, 8'hFF);
        step();
        chk("t6_valid_after", {7'd0, irq_valid}, 8'h01);
        chk("t6_id_after", {5'd0, irq_id}, 8'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
